if_id_stage_register: RTL and testbench
=======================================

# if_id_stage_register

IF/ID pipeline register and stage-control block: the consumer of the load-use stall protocol. It captures the fetched instruction and PC+4 each cycle, holds them while `IF_ID_Write` is deasserted, and squashes them to a NOP bubble on branch flush. It also feeds the ID-stage `Rs`/`Rt` fields back to the hazard detector. It sits between the fetch stage and the decode/register-file stage, and it carries stall/flush performance counters and a stuck-stall watchdog for debug.

## Interface
- `DATA_WIDTH`, 32: instruction and PC width.
- `CNT_WIDTH`, 16: width of the stall and flush performance counters.
- `MAX_HOLD`, 8: consecutive hold cycles after which the watchdog trips (valid range 1..255).

Ports (clock and reset first):
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `IF_ID_Write`  in  1  1 = load a new fetch; 0 = hold current contents (stall).
- `IF_Flush`  in  1  1 = squash: load a bubble regardless of `IF_ID_Write`.
- `IF_Valid`  in  1  fetch-side data is a real instruction.
- `IF_PCPlus4`  in  DATA_WIDTH  fetched PC+4.
- `IF_Instruction`  in  DATA_WIDTH  fetched instruction word.
- `ID_PCPlus4`  out  DATA_WIDTH  registered PC+4.
- `ID_Instruction`  out  DATA_WIDTH  registered instruction; 0 (`sll $0,$0,0`) when bubble.
- `ID_Valid`  out  1  registered instruction is real.
- `IF_ID_RegisterRs`  out  5  `ID_Instruction[25:21]`, combinational from register.
- `IF_ID_RegisterRt`  out  5  `ID_Instruction[20:16]`, combinational from register.
- `StallCount`  out  CNT_WIDTH  cycles held with a valid instruction; saturating.
- `FlushCount`  out  CNT_WIDTH  flushes that killed a valid instruction; saturating.
- `HoldTimeout`  out  1  sticky watchdog flag.

## Operation
- Update priority per cycle: `Rst` > `IF_Flush` > hold (`IF_ID_Write`=0) > load.
- **Rst:**
  - `ID_PCPlus4`, `ID_Instruction`, `ID_Valid`, `StallCount`, `FlushCount`, `HoldTimeout` all 0.
  - Internal hold-run counter 0; state EMPTY.
- **Flush:**
  - `ID_Instruction`←0, `ID_PCPlus4`←0, `ID_Valid`←0; hold-run counter←0; next state EMPTY.
  - `FlushCount`+1 only if `ID_Valid` was 1 or `IF_Valid` is 1 (a real instruction dies).
- **Hold:**
  - All data registers keep their value.
  - If `ID_Valid`=1: `StallCount`+1 and hold-run counter+1 (saturate at 255).
  - If `ID_Valid`=0: counters unchanged.
- **Load:**
  - If `IF_Valid`=1: capture `IF_PCPlus4`/`IF_Instruction`, `ID_Valid`←1.
  - If `IF_Valid`=0: load bubble (0, 0, `ID_Valid`=0).
  - Hold-run counter←0.
- **State machine** (3 states, encoding free):
  - EMPTY (`ID_Valid`=0): load with `IF_Valid`=1 → FULL; anything else → EMPTY.
  - FULL (valid, not held last cycle): hold → STALLED; load valid → FULL; load invalid or flush → EMPTY.
  - STALLED (valid, held ≥1 cycle): hold → STALLED; load valid → FULL; load invalid or flush → EMPTY.
- **Watchdog:** `HoldTimeout`←1 on the edge where the hold-run counter reaches `MAX_HOLD`. It clears only on `Rst`; flush and load do not clear it.
- **Saturation:** `StallCount` and `FlushCount` stop at 2^CNT_WIDTH−1 and never wrap.
- **Simultaneous flush and hold:** flush wins; no stall is counted that cycle.

## Timing
- Latency: 1 cycle from `IF_*` to `ID_*`.
- `IF_ID_RegisterRs`/`IF_ID_RegisterRt` are valid in the same cycle as `ID_Instruction`, with no extra register, so the hazard detector sees them combinationally.
- A hold issued in cycle N keeps the cycle-N `ID_*` values at edge N+1.
- Counter increments are visible the cycle after the qualifying event.
- `HoldTimeout` rises exactly `MAX_HOLD` edges after the first counted hold of an uninterrupted valid stall run.
- Reset mid-stall or mid-flush: all outputs reach reset values at the next edge; the hold-run restarts from 0.

## Test plan
- **Reset:** assert `Rst` 2 cycles with `IF_Valid`=1, `IF_Instruction`=0x8C220004 → all outputs 0 and `ID_Valid`=0 during and after the reset edge.
- **Load:** `IF_ID_Write`=1, `IF_Valid`=1, `IF_PCPlus4`=0x00000008, `IF_Instruction`=0x8C220004 → next cycle `ID_Instruction`=0x8C220004, `IF_ID_RegisterRs`=1, `IF_ID_RegisterRt`=2, `ID_Valid`=1.
- **Load-use stall:** after the load above, `IF_ID_Write`=0 for 1 cycle with new `IF_Instruction`=0x00431020 → `ID_Instruction` stays 0x8C220004 and `StallCount`=1. Then `IF_ID_Write`=1 → `ID_Instruction`=0x00431020.
- **Flush over hold:** `IF_Flush`=1, `IF_ID_Write`=0, `ID_Valid`=1 → next cycle `ID_Instruction`=0, `ID_Valid`=0, `FlushCount`=1, `StallCount` unchanged.
- **Watchdog:** `MAX_HOLD`=8; hold 7 cycles with a valid instruction → `HoldTimeout`=0. Hold an 8th cycle → `HoldTimeout`=1. Release and then flush → `HoldTimeout` stays 1 until `Rst`.
- **Saturation:** `CNT_WIDTH`=4; hold a valid instruction 20 cycles → `StallCount`=15 and held there.

Source files
------------

// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register with stall hold, flush-to-bubble, Rs/Rt feedback for the
// hazard detector, saturating stall/flush performance counters and a sticky hold watchdog.
module if_id_stage_register #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  IF_ID_Write,
    input  logic                  IF_Flush,
    input  logic                  IF_Valid,
    input  logic [DATA_WIDTH-1:0] IF_PCPlus4,
    input  logic [DATA_WIDTH-1:0] IF_Instruction,
    output logic [DATA_WIDTH-1:0] ID_PCPlus4,
    output logic [DATA_WIDTH-1:0] ID_Instruction,
    output logic                  ID_Valid,
    output logic [4:0]            IF_ID_RegisterRs,
    output logic [4:0]            IF_ID_RegisterRt,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount,
    output logic                  HoldTimeout
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_STALLED
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX  = '1;
    localparam logic [7:0]           LP_RUN_MAX  = 8'hFF;
    localparam logic [8:0]           LP_MAX_HOLD = 9'(MAX_HOLD);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc_plus4;
    logic [DATA_WIDTH-1:0] r_instruction;
    logic [CNT_WIDTH-1:0]  r_stall_count;
    logic [CNT_WIDTH-1:0]  r_flush_count;
    logic [7:0]            r_hold_run;
    logic                  r_hold_timeout;

    logic                  w_id_valid;
    logic                  w_real_kill;
    logic [8:0]            w_hold_run_inc;

    // Valid is simply "not EMPTY", so the state register is the single source of truth.
    assign w_id_valid     = (r_state != S_EMPTY);
    assign w_real_kill    = w_id_valid || IF_Valid;
    assign w_hold_run_inc = {1'b0, r_hold_run} + 9'd1;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values, regardless of statement order within this block.
        if (Rst) begin
            r_state        <= S_EMPTY;
            r_pc_plus4     <= '0;
            r_instruction  <= '0;
            r_stall_count  <= '0;
            r_flush_count  <= '0;
            r_hold_run     <= '0;
            r_hold_timeout <= 1'b0;
        end else if (IF_Flush) begin
            r_state       <= S_EMPTY;
            r_pc_plus4    <= '0;
            r_instruction <= '0;
            r_hold_run    <= '0;
            if (w_real_kill && (r_flush_count != LP_CNT_MAX))
                r_flush_count <= r_flush_count + 1'b1;
        end else if (!IF_ID_Write) begin
            // Only a held real instruction counts as a stall; holding a bubble is free.
            if (w_id_valid) begin
                r_state <= S_STALLED;
                if (r_stall_count != LP_CNT_MAX)
                    r_stall_count <= r_stall_count + 1'b1;
                if (r_hold_run != LP_RUN_MAX)
                    r_hold_run <= w_hold_run_inc[7:0];
                if (w_hold_run_inc == LP_MAX_HOLD)
                    r_hold_timeout <= 1'b1;
            end
        end else begin
            r_hold_run <= '0;
            if (IF_Valid) begin
                r_state       <= S_FULL;
                r_pc_plus4    <= IF_PCPlus4;
                r_instruction <= IF_Instruction;
            end else begin
                r_state       <= S_EMPTY;
                r_pc_plus4    <= '0;
                r_instruction <= '0;
            end
        end
    end

    assign ID_PCPlus4       = r_pc_plus4;
    assign ID_Instruction   = r_instruction;
    assign ID_Valid         = w_id_valid;
    assign IF_ID_RegisterRs = r_instruction[25:21];
    assign IF_ID_RegisterRt = r_instruction[20:16];
    assign StallCount       = r_stall_count;
    assign FlushCount       = r_flush_count;
    assign HoldTimeout      = r_hold_timeout;

endmodule

// File: tb/tb_if_id_stage_register.sv
// Directed scoreboard bench for if_id_stage_register: a default instance plus a
// CNT_WIDTH=4 instance on the same stimulus to exercise counter saturation.
module tb_if_id_stage_register;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IF_ID_Write;
    logic        IF_Flush;
    logic        IF_Valid;
    logic [31:0] IF_PCPlus4;
    logic [31:0] IF_Instruction;

    logic [31:0] ID_PCPlus4, ID_Instruction;
    logic        ID_Valid, HoldTimeout;
    logic [4:0]  IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic [15:0] StallCount, FlushCount;

    logic [31:0] s_pc, s_instr;
    logic        s_valid, s_timeout;
    logic [4:0]  s_rs, s_rt;
    logic [3:0]  s_stall, s_flush;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    if_id_stage_register dut (
        .Clk(Clk), .Rst(Rst), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
        .IF_Valid(IF_Valid), .IF_PCPlus4(IF_PCPlus4), .IF_Instruction(IF_Instruction),
        .ID_PCPlus4(ID_PCPlus4), .ID_Instruction(ID_Instruction), .ID_Valid(ID_Valid),
        .IF_ID_RegisterRs(IF_ID_RegisterRs), .IF_ID_RegisterRt(IF_ID_RegisterRt),
        .StallCount(StallCount), .FlushCount(FlushCount), .HoldTimeout(HoldTimeout)
    );

    if_id_stage_register #(.CNT_WIDTH(4)) dut_sat (
        .Clk(Clk), .Rst(Rst), .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush),
        .IF_Valid(IF_Valid), .IF_PCPlus4(IF_PCPlus4), .IF_Instruction(IF_Instruction),
        .ID_PCPlus4(s_pc), .ID_Instruction(s_instr), .ID_Valid(s_valid),
        .IF_ID_RegisterRs(s_rs), .IF_ID_RegisterRt(s_rt),
        .StallCount(s_stall), .FlushCount(s_flush), .HoldTimeout(s_timeout)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] stall;
        logic [15:0] flush;
        logic        timeout;
        logic [3:0]  stall4;
        logic [3:0]  flush4;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (what the ID side should hold after each edge).
    logic [31:0] m_pc, m_instr;
    logic        m_valid, m_to;
    logic [15:0] m_stall, m_flush;
    logic [3:0]  m_stall4, m_flush4;
    int          m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic wr, input logic fl, input logic vl,
                         input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_valid = 0; m_to = 0; m_run = 0;
            m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        end else if (fl) begin
            if (m_valid || vl) begin
                if (m_flush != 16'hFFFF) m_flush = m_flush + 1;
                if (m_flush4 != 4'hF) m_flush4 = m_flush4 + 1;
            end
            m_pc = 0; m_instr = 0; m_valid = 0; m_run = 0;
        end else if (!wr) begin
            if (m_valid) begin
                if (m_stall != 16'hFFFF) m_stall = m_stall + 1;
                if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 1;
                if (m_run < 255) m_run = m_run + 1;
                if (m_run == 8) m_to = 1;
            end
        end else begin
            m_run = 0;
            m_valid = vl;
            m_pc = vl ? pc : 32'h0;
            m_instr = vl ? ins : 32'h0;
        end
        e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.stall = m_stall;
        e.flush = m_flush; e.timeout = m_to; e.stall4 = m_stall4; e.flush4 = m_flush4;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, advance one edge, then compare against the scoreboard.
    task automatic step(input logic rst, input logic wr, input logic fl, input logic vl,
                        input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        Rst = rst; IF_ID_Write = wr; IF_Flush = fl; IF_Valid = vl;
        IF_PCPlus4 = pc; IF_Instruction = ins;
        model(rst, wr, fl, vl, pc, ins);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("pc", ID_PCPlus4, e.pc);
            check("instr", ID_Instruction, e.instr);
            check("valid", {31'd0, ID_Valid}, {31'd0, e.valid});
            check("rs", {27'd0, IF_ID_RegisterRs}, {27'd0, e.instr[25:21]});
            check("rt", {27'd0, IF_ID_RegisterRt}, {27'd0, e.instr[20:16]});
            check("stall", {16'd0, StallCount}, {16'd0, e.stall});
            check("flush", {16'd0, FlushCount}, {16'd0, e.flush});
            check("timeout", {31'd0, HoldTimeout}, {31'd0, e.timeout});
            check("stall4", {28'd0, s_stall}, {28'd0, e.stall4});
            check("flush4", {28'd0, s_flush}, {28'd0, e.flush4});
        end
    endtask

    initial begin
        Rst = 1; IF_ID_Write = 1; IF_Flush = 0; IF_Valid = 1;
        IF_PCPlus4 = 32'h8; IF_Instruction = 32'h8C22_0004;

        // Reset for two cycles with a real fetch presented.
        step(1, 1, 0, 1, 32'h8, 32'h8C22_0004);
        step(1, 1, 0, 1, 32'h8, 32'h8C22_0004);
        check("reset_valid", {31'd0, ID_Valid}, 32'd0);
        check("reset_instr", ID_Instruction, 32'd0);

        // Load: lw $2,4($1).
        step(0, 1, 0, 1, 32'h8, 32'h8C22_0004);
        check("load_instr", ID_Instruction, 32'h8C22_0004);
        check("load_rs", {27'd0, IF_ID_RegisterRs}, 32'd1);
        check("load_rt", {27'd0, IF_ID_RegisterRt}, 32'd2);
        check("load_valid", {31'd0, ID_Valid}, 32'd1);

        // Load-use stall for one cycle, then release.
        step(0, 0, 0, 1, 32'hC, 32'h0043_1020);
        check("stall_hold_instr", ID_Instruction, 32'h8C22_0004);
        check("stall_count_1", {16'd0, StallCount}, 32'd1);
        step(0, 1, 0, 1, 32'hC, 32'h0043_1020);
        check("stall_release_instr", ID_Instruction, 32'h0043_1020);

        // Flush wins over hold.
        step(0, 0, 1, 1, 32'h10, 32'h0000_0000);
        check("flush_instr", ID_Instruction, 32'd0);
        check("flush_count_1", {16'd0, FlushCount}, 32'd1);
        check("flush_stall_same", {16'd0, StallCount}, 32'd1);

        // Flush of nothing real is not counted; hold of a bubble is not a stall.
        step(0, 1, 1, 0, 32'h14, 32'h1234_5678);
        check("flush_empty_count", {16'd0, FlushCount}, 32'd1);
        step(0, 0, 0, 1, 32'h18, 32'h2345_6789);
        check("bubble_hold_stall", {16'd0, StallCount}, 32'd1);
        step(0, 1, 0, 0, 32'h1C, 32'h3456_789A);
        check("invalid_load_bubble", ID_Instruction, 32'd0);

        // Watchdog: 7 holds quiet, 8th trips, survives release and flush.
        step(0, 1, 0, 1, 32'h20, 32'h8C64_0000);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 32'h24, 32'h0085_3020);
        check("wd_7_holds", {31'd0, HoldTimeout}, 32'd0);
        step(0, 0, 0, 1, 32'h24, 32'h0085_3020);
        check("wd_8_holds", {31'd0, HoldTimeout}, 32'd1);
        step(0, 1, 0, 1, 32'h24, 32'h0085_3020);
        step(0, 1, 1, 1, 32'h28, 32'h0000_0000);
        check("wd_sticky", {31'd0, HoldTimeout}, 32'd1);
        check("flush_count_2", {16'd0, FlushCount}, 32'd2);

        // Reset clears the watchdog.
        step(1, 1, 0, 0, 32'h0, 32'h0);
        check("wd_reset", {31'd0, HoldTimeout}, 32'd0);

        // Saturation: 20 holds of a valid instruction.
        step(0, 1, 0, 1, 32'h30, 32'hAC22_0008);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 32'h34, 32'h0000_0000);
        check("sat_stall4", {28'd0, s_stall}, 32'd15);
        check("sat_stall16", {16'd0, StallCount}, 32'd20);
        step(0, 0, 0, 1, 32'h34, 32'h0000_0000);
        check("sat_stall4_held", {28'd0, s_stall}, 32'd15);

        // Reset mid-stall returns everything to zero.
        step(1, 0, 0, 1, 32'h38, 32'hFFFF_FFFF);
        check("reset_mid_stall", {16'd0, StallCount}, 32'd0);
        step(0, 0, 0, 1, 32'h3C, 32'h1111_1111);
        check("post_reset_empty", {31'd0, ID_Valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
